cim_bitserial_mac: RTL
======================

# cim_bitserial_mac

Parametrised bit-serial multiply-accumulate column for the digital CIM macro. It accepts one activation bit-plane per cycle against a stationary weight vector of ROWS × WBITS bits. Each plane is reduced through a signed/unsigned adder tree, and the plane sums are shift-accumulated over a run-time-selectable number of activation bits. The result is returned through a valid/ready output. It generalises the one-shot 4-bit, 144-row local MAC column to configurable rows, weight width and activation precision, with signed activations and backpressure.

## Interface
Parameters:
- ROWS, 144: rows summed per column; any value ≥ 2.
- WBITS, 4: weight bits per row.
- XBITS_MAX, 8: maximum activation precision in bit-planes.
- PS_W, WBITS + $clog2(ROWS): plane-sum width, derived, not overridable.
- ACC_W, PS_W + XBITS_MAX: accumulator and result width, derived.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active low.
- cfg_w_signed  in  1  1: weights are two's complement; 0: unsigned.
- cfg_x_signed  in  1  1: activations are two's complement, so the final plane has negative weight; 0: unsigned.
- cfg_nbits  in  $clog2(XBITS_MAX+1)  planes per vector. Sampled with the first plane of each vector. 0 or values above XBITS_MAX are treated as XBITS_MAX.
- wt  in  ROWS*WBITS  weights; row r is wt[r*WBITS +: WBITS]. Must be stable from the first plane of a vector until its result is accepted.
- in_valid  in  1  in_bits holds a valid plane.
- in_ready  out  1  block accepts a plane this cycle.
- in_bits  in  ROWS  activation bit-plane, LSB plane first.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  signed (if either cfg bit is set) or unsigned dot product.

## Operation
- Global advance: adv = !out_valid || out_ready; in_ready = adv, combinational. The whole pipeline holds when adv = 0.
- Plane transfer: in_valid && in_ready.
- Control FSM:
  - IDLE: plane counter cnt = 0. A plane transfer latches nbits and cfg bits, tags the plane first, and goes to BUSY. If nbits = 1, the plane is also tagged last and the FSM stays in IDLE.
  - BUSY: each transfer increments cnt. The plane with cnt == nbits-1 is tagged last and the FSM returns to IDLE.
- cfg changes during BUSY are ignored.
- Stage 1 (tree):
  - term_r = in_bits[r] ? wt_r : 0.
  - Each term is sign-extended if w_signed, else zero-extended, to PS_W.
  - Summed and registered as ps, together with tags first, last, neg and index k.
  - neg = x_signed && last.
- Stage 2 (accumulate): t = (neg ? -ps : ps) extended to ACC_W, shifted left by k. acc <= (first ? 0 : acc) + t.
- Result capture: when the last-tagged plane accumulates, out_data <= the new acc value and out_valid <= 1. out_valid clears on out_valid && out_ready, unless a new result is captured in the same cycle.
- Arithmetic is modulo 2^ACC_W. No overflow is possible with the derived widths.
- Back-to-back vectors: the first plane of vector n+1 may transfer in the cycle after the last plane of vector n. The first tag resets the accumulator, so there are no bubbles.

## Timing
- Reset values: out_valid 0, out_data 0, in_ready 1, FSM IDLE, cnt 0, all pipeline valid bits 0, acc 0.
- Latency: last plane transferred in cycle T gives out_valid = 1 in cycle T+2, provided adv stays high.
- Throughput: one plane per cycle. An N-plane vector occupies N input cycles.
- Stall: with out_valid && !out_ready, in_ready = 0. Stage registers, acc and out_data hold unchanged.
- Reset mid-vector: all state clears immediately. A partial vector is discarded and the next plane is treated as first.
- in_valid low mid-vector: the FSM waits in BUSY indefinitely. No timeout.

## Structure
- Package cim_mac_pkg holds:
  - width functions for PS_W and ACC_W;
  - the nbits clamp function;
  - the FSM state enum (IDLE, BUSY).
- Sub-module cim_plane_tree: combinational, parametrised on ROWS, WBITS and signed mode. It performs bit-plane gating plus a balanced log2 adder tree, handling odd counts by passing the unpaired node up. Its output is registered by the parent.
- The parent holds the FSM, stage registers, accumulator and output register.

## Test plan
- Unsigned max, default parameters: all weights 4'hF; 8 planes of all ones; nbits 8; both cfg bits 0 -> out_data = 550800 at T+2.
- Signed weights and activations: all weights 4'b1000 (-8); planes 0–6 zero, plane 7 all ones (x = -128); nbits 8 -> out_data = 147456.
- Signed activation -1 × weight 7: all rows; cfg_x_signed 1, cfg_w_signed 1 -> out_data = -1008 (20'hFFC10).
- Backpressure: two back-to-back 2-plane vectors with out_ready held 0 for 5 cycles after the first result ->
  - in_ready is 0 while out_valid is pending;
  - the first result is stable until accepted;
  - the second result is correct;
  - no plane is lost.
- nbits edge values:
  - cfg_nbits 1, plane with row 0 = 1, w0 = 9, unsigned -> 9, with a new result every cycle at full rate;
  - cfg_nbits 0 behaves as 8.
- Reset mid-vector: assert rst_n low after 3 of 8 planes, then send a fresh 8-plane vector -> outputs are at reset values during reset, and the fresh result is unaffected by the discarded planes.

Source files
------------

// File: rtl/cim_mac_pkg.sv
// Shared widths, nbits clamp and control-state encoding for the bit-serial CIM MAC column.
package cim_mac_pkg;

  function automatic int unsigned ps_width(input int unsigned rows, input int unsigned wbits);
    return wbits + $clog2(rows);
  endfunction

  function automatic int unsigned acc_width(input int unsigned ps_w, input int unsigned xbits);
    return ps_w + xbits;
  endfunction

  // Zero or out-of-range precision falls back to the widest supported vector.
  function automatic int unsigned clamp_nbits(input int unsigned nbits, input int unsigned xbits_max);
    return (nbits == 0 || nbits > xbits_max) ? xbits_max : nbits;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/cim_plane_tree.sv
// Combinational bit-plane gating and balanced adder tree; unpaired nodes ride up a level.
module cim_plane_tree
  import cim_mac_pkg::*;
#(
  parameter int unsigned ROWS  = 144,
  parameter int unsigned WBITS = 4
) (
  input  logic [ROWS-1:0]                   i_bits,
  input  logic [ROWS*WBITS-1:0]             i_wt,
  input  logic                              i_w_signed,
  output logic [ps_width(ROWS, WBITS)-1:0]  o_sum
);

  localparam int unsigned PS_W   = ps_width(ROWS, WBITS);
  localparam int unsigned LEVELS = $clog2(ROWS);

  function automatic int unsigned lvl_nodes(input int unsigned lvl);
    return (ROWS + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

  function automatic int unsigned lvl_base(input int unsigned lvl);
    int unsigned base;
    base = 0;
    for (int unsigned l = 0; l < lvl; l++) base += lvl_nodes(l);
    return base;
  endfunction

  localparam int unsigned NODES = lvl_base(LEVELS + 1);

  // All tree levels packed into one node array; level l starts at lvl_base(l).
  logic [PS_W-1:0] w_node [NODES];

  genvar r, l, n;
  for (r = 0; r < ROWS; r++) begin : g_leaf
    logic [WBITS-1:0] w_wt;
    assign w_wt      = i_wt[r*WBITS +: WBITS];
    assign w_node[r] = i_bits[r] ? {{(PS_W-WBITS){i_w_signed & w_wt[WBITS-1]}}, w_wt} : '0;
  end

  for (l = 1; l <= LEVELS; l++) begin : g_lvl
    for (n = 0; n < lvl_nodes(l); n++) begin : g_node
      localparam int unsigned SRC = lvl_base(l - 1) + 2 * n;
      localparam int unsigned DST = lvl_base(l) + n;
      if (2 * n + 1 < lvl_nodes(l - 1)) begin : g_add
        assign w_node[DST] = w_node[SRC] + w_node[SRC+1];
      end else begin : g_pass
        assign w_node[DST] = w_node[SRC];
      end
    end
  end

  assign o_sum = w_node[NODES-1];

endmodule

// File: rtl/cim_bitserial_mac.sv
// Bit-serial MAC column: plane-tree stage, shift-accumulate stage, valid/ready result register.
module cim_bitserial_mac
  import cim_mac_pkg::*;
#(
  parameter int unsigned ROWS      = 144,
  parameter int unsigned WBITS     = 4,
  parameter int unsigned XBITS_MAX = 8
) (
  input  logic                                                     clk,
  input  logic                                                     rst_n,
  input  logic                                                     cfg_w_signed,
  input  logic                                                     cfg_x_signed,
  input  logic [$clog2(XBITS_MAX+1)-1:0]                           cfg_nbits,
  input  logic [ROWS*WBITS-1:0]                                    wt,
  input  logic                                                     in_valid,
  output logic                                                     in_ready,
  input  logic [ROWS-1:0]                                          in_bits,
  output logic                                                     out_valid,
  input  logic                                                     out_ready,
  output logic [acc_width(ps_width(ROWS, WBITS), XBITS_MAX)-1:0]   out_data
);

  localparam int unsigned PS_W  = ps_width(ROWS, WBITS);
  localparam int unsigned ACC_W = acc_width(PS_W, XBITS_MAX);
  localparam int unsigned NB_W  = $clog2(XBITS_MAX + 1);

  state_t            r_state;
  logic [NB_W-1:0]   r_cnt;
  logic [NB_W-1:0]   r_nbits;
  logic              r_w_signed;
  logic              r_x_signed;

  logic              r_s1_vld;
  logic              r_s1_first;
  logic              r_s1_last;
  logic              r_s1_neg;
  logic              r_s1_w_signed;
  logic [NB_W-1:0]   r_s1_k;
  logic [PS_W-1:0]   r_ps;

  logic [ACC_W-1:0]  r_acc;

  logic              w_adv;
  logic              w_xfer;
  logic              w_idle;
  logic [NB_W-1:0]   w_nbits;
  logic              w_w_signed;
  logic              w_x_signed;
  logic              w_last;
  logic [PS_W-1:0]   w_ps;
  logic [ACC_W-1:0]  w_ext;
  logic [ACC_W-1:0]  w_term;
  logic [ACC_W-1:0]  w_acc_nxt;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_xfer   = in_valid && w_adv;

  // The first plane of a vector uses live cfg; later planes use the values latched with it.
  assign w_idle     = (r_state == IDLE);
  assign w_nbits    = w_idle ? NB_W'(clamp_nbits(32'(cfg_nbits), XBITS_MAX)) : r_nbits;
  assign w_w_signed = w_idle ? cfg_w_signed : r_w_signed;
  assign w_x_signed = w_idle ? cfg_x_signed : r_x_signed;
  assign w_last     = (r_cnt == w_nbits - NB_W'(1));

  cim_plane_tree #(
    .ROWS  (ROWS),
    .WBITS (WBITS)
  ) u_tree (
    .i_bits     (in_bits),
    .i_wt       (wt),
    .i_w_signed (w_w_signed),
    .o_sum      (w_ps)
  );

  // Plane-sequencing FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_nbits    <= NB_W'(XBITS_MAX);
      r_w_signed <= 1'b0;
      r_x_signed <= 1'b0;
    end else if (w_xfer) begin
      if (w_idle) begin
        r_nbits    <= w_nbits;
        r_w_signed <= cfg_w_signed;
        r_x_signed <= cfg_x_signed;
      end
      if (w_last) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= BUSY;
        r_cnt   <= r_cnt + NB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld      <= 1'b0;
      r_s1_first    <= 1'b0;
      r_s1_last     <= 1'b0;
      r_s1_neg      <= 1'b0;
      r_s1_w_signed <= 1'b0;
      r_s1_k        <= '0;
      r_ps          <= '0;
    end else if (w_adv) begin
      r_s1_vld      <= w_xfer;
      r_s1_first    <= w_idle;
      r_s1_last     <= w_last;
      r_s1_neg      <= w_x_signed && w_last;
      r_s1_w_signed <= w_w_signed;
      r_s1_k        <= r_cnt;
      r_ps          <= w_ps;
    end
  end

  // The MSB plane of a signed activation carries negative weight.
  assign w_ext     = {{(ACC_W-PS_W){r_s1_w_signed & r_ps[PS_W-1]}}, r_ps};
  assign w_term    = (r_s1_neg ? (ACC_W'(0) - w_ext) : w_ext) << r_s1_k;
  assign w_acc_nxt = (r_s1_first ? ACC_W'(0) : r_acc) + w_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (w_adv) begin
      out_valid <= r_s1_vld && r_s1_last;
      if (r_s1_vld) begin
        r_acc <= w_acc_nxt;
        if (r_s1_last) out_data <= w_acc_nxt;
      end
    end
  end

endmodule
